mult_div: RTL and testbench

//  Sequential signed multiply/divide unit for the multicycle CPU datapath.

---
 rtl/mult_div_pkg.sv | 21 ++
 rtl/mult_div_div_step.sv | 29 ++
 rtl/mult_div.sv | 147 ++++++++++++++
 tb/tb_mult_div.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide unit and the control unit that drives it.
// Pure declarations: no latency, no flow control.
package mult_div_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_MULT = 3'd1;
    localparam state_t ST_DIV  = 3'd2;
    localparam state_t ST_FIX  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam int DEF_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mult_div_div_step.sv
// One restoring-division iteration on magnitudes; purely combinational, zero latency.
// No flow control: the caller decides when to register the result.
module mult_div_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // One guard bit above the remainder keeps the trial-subtract sign unambiguous.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {2'b00, dvs};
        if (diff[WIDTH+1]) begin
            rem_out = shifted[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = diff[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div.sv
// Sequential signed Booth multiply / restoring divide; WIDTH+2 cycles start-to-done, 1 for divide-by-zero.
// No backpressure: starts are only accepted in IDLE and ignored while an operation is in flight.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;       // Booth accumulator or division remainder
    logic [WIDTH-1:0] q;         // multiplier or quotient
    logic             q_m1;
    logic [WIDTH-1:0] opd;       // multiplicand or divisor magnitude
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             dz;

    logic             last;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH-1:0] div_quo;

    assign last = (cnt == CW'(1));

    always_comb begin
        m_ext = {opd[WIDTH-1], opd};
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
    end

    mult_div_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (acc),
        .quo_in  (q),
        .dvs     (opd),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mult_start)                         state_nxt = ST_MULT;
                else if (div_start && b_in == '0)      state_nxt = ST_DONE;
                else if (div_start)                     state_nxt = ST_DIV;
            end
            ST_MULT: if (last) state_nxt = ST_FIX;
            ST_DIV:  if (last) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_MULT) || (state == ST_DIV) || (state == ST_FIX);
        done     = (state == ST_DONE);
        div_zero = (state == ST_DONE) && dz;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            opd    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mult_start) begin
                        opd    <= a_in;
                        q      <= b_in;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        cnt    <= CW'(WIDTH);
                        is_div <= 1'b0;
                        dz     <= 1'b0;
                    end else if (div_start) begin
                        opd    <= b_in[WIDTH-1] ? -b_in : b_in;
                        q      <= a_in[WIDTH-1] ? -a_in : a_in;
                        acc    <= '0;
                        sign_a <= a_in[WIDTH-1];
                        sign_b <= b_in[WIDTH-1];
                        cnt    <= CW'(WIDTH);
                        is_div <= 1'b1;
                        dz     <= (b_in == '0);
                    end
                end
                ST_MULT: begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q    <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                    cnt  <= cnt - 1'b1;
                end
                ST_DIV: begin
                    acc <= div_rem;
                    q   <= div_quo;
                    cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    if (is_div) begin
                        lo_out <= (sign_a ^ sign_b) ? -q : q;
                        hi_out <= sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        hi_out <= acc[WIDTH-1:0];
                        lo_out <= q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Randomised and directed stimulus for mult_div, checked by a queue-based scoreboard
// against a plain 64-bit arithmetic reference.
module tb_mult_div;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         mult_start;
    logic         div_start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         busy;
    logic         done;
    logic         div_zero;

    mult_div #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a_in       (a_in),
        .b_in       (b_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           done_cyc;
    } exp_t;

    exp_t         scb[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;
    logic         prev_done = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset && done) begin
            chk("busy_low_at_done", 64'(busy), 64'd0);
            chk("done_single_cycle", 64'(prev_done), 64'd0);
            if (scb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = scb.pop_front();
                chk("hi_out", 64'(hi_out), 64'(e.hi));
                chk("lo_out", 64'(lo_out), 64'(e.lo));
                chk("div_zero", 64'(div_zero), 64'(e.dz));
                chk("done_latency", 64'(cyc), 64'(e.done_cyc));
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while ((busy || done) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, p, qq, rr;
        int     lat;
        wait_idle();
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        lat = W + 1;
        e.dz = 1'b0;
        if (m) begin
            p = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == '0) begin
            e.hi = model_hi;
            e.lo = model_lo;
            e.dz = 1'b1;
            lat  = 0;
        end else begin
            qq = sa / sbv;
            rr = sa % sbv;
            e.hi = rr[31:0];
            e.lo = qq[31:0];
        end
        model_hi   = e.hi;
        model_lo   = e.lo;
        e.done_cyc = cyc + 1 + lat;
        scb.push_back(e);
        a_in       = a;
        b_in       = b;
        mult_start = m;
        div_start  = d;
        @(negedge clock);
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] edge_vals [5];
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'h0000_0001;
        edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h8000_0000;
        edge_vals[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return W'($signed(16'($urandom)));
        return W'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a_in       = '0;
        b_in       = '0;
        repeat (3) @(negedge clock);
        chk("reset_hi", 64'(hi_out), 64'd0);
        chk("reset_lo", 64'(lo_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_div_zero", 64'(div_zero), 64'd0);
        reset = 1'b1;

        issue(1'b1, 1'b0, 32'd7, -32'sd3);

        issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        for (int k = 0; k <= W; k++) begin
            chk("busy_during_mult", 64'(busy), 64'd1);
            @(negedge clock);
        end

        issue(1'b0, 1'b1, -32'sd7, 32'd2);
        issue(1'b0, 1'b1, 32'd100, 32'd7);

        issue(1'b0, 1'b1, 32'h0246_9234, 32'h0000_2000);
        issue(1'b0, 1'b1, 32'd5, 32'd0);

        // Starts arriving mid-divide must not disturb it.
        issue(1'b0, 1'b1, -32'sd1000, 32'd33);
        repeat (8) @(negedge clock);
        a_in       = 32'h5555_5555;
        b_in       = 32'd0;
        mult_start = 1'b1;
        div_start  = 1'b1;
        @(negedge clock);
        mult_start = 1'b0;
        div_start  = 1'b0;

        issue(1'b1, 1'b1, 32'd123, -32'sd456);
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a multiply discards it.
        issue(1'b1, 1'b0, 32'd99, 32'd77);
        repeat (13) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_hi", 64'(hi_out), 64'd0);
        chk("async_reset_lo", 64'(lo_out), 64'd0);
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_done", 64'(done), 64'd0);
        void'(scb.pop_back());
        model_hi = '0;
        model_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        issue(1'b1, 1'b0, 32'd3, 32'd4);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = pick();
            rb = pick();
            if ($urandom_range(0, 1) == 0) begin
                issue(1'b1, 1'b0, ra, rb);
            end else begin
                if ($urandom_range(0, 7) == 0) rb = '0;
                issue(1'b0, 1'b1, ra, rb);
            end
        end

        begin
            int n = 0;
            while (scb.size() != 0 && n < 200) begin
                @(negedge clock);
                n++;
            end
            if (scb.size() != 0) chk("scoreboard_drain", 64'(scb.size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
